// File: rtl/sti_rx_pkg.sv
// Shared types and helpers for the STI receiver: length encodings, FSM states,
// frame-size and payload-recovery functions.
package sti_rx_pkg;

    localparam int STI_W_MAX = 32;
    localparam int STI_CNT_W = 5;

    localparam logic [1:0] LEN_8  = 2'b00;
    localparam logic [1:0] LEN_16 = 2'b01;
    localparam logic [1:0] LEN_24 = 2'b10;
    localparam logic [1:0] LEN_32 = 2'b11;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_RECV,
        RX_WAITLOW
    } rx_state_t;

    typedef struct packed {
        logic [15:0] pi;
        logic        pad_err;
    } pi_res_t;

    function automatic logic [5:0] nbits(input logic [1:0] len);
        return ({4'b0000, len} + 6'd1) << 3;
    endfunction

    function automatic pi_res_t extract_pi(input logic [31:0] w, input logic [1:0] len,
                                           input logic fill, input logic low);
        pi_res_t r;
        r.pi      = w[15:0];
        r.pad_err = 1'b0;
        case (len)
            LEN_8:   r.pi = low ? {w[7:0], 8'h00} : {8'h00, w[7:0]};
            LEN_16:  r.pi = w[15:0];
            LEN_24: begin
                r.pi      = fill ? w[23:8] : w[15:0];
                r.pad_err = fill ? |w[7:0] : |w[23:16];
            end
            default: begin
                r.pi      = fill ? w[31:16] : w[15:0];
                r.pad_err = fill ? |w[15:0] : |w[31:16];
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sti_rx_if.sv
// Serial input and parallel ready/valid output of the STI receiver.
// master = link/consumer side, slave = receiver.
interface sti_rx_if;
    logic                              si_valid;
    logic                              si_data;
    logic                              po_valid;
    logic                              po_ready;
    logic [sti_rx_pkg::STI_W_MAX-1:0]  po_word;
    logic [15:0]                       po_pi;
    logic [1:0]                        po_len;

    modport master (output si_valid, si_data, po_ready,
                    input  po_valid, po_word, po_pi, po_len);
    modport slave  (input  si_valid, si_data, po_ready,
                    output po_valid, po_word, po_pi, po_len);
endinterface

// File: rtl/sti_rx_obuf.sv
// One-entry ready/valid holding register; loads one cycle after ld is seen.
// Full and not draining when ld arrives: new word dropped, err_ovf set (sticky).
module sti_rx_obuf
    import sti_rx_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 ld,
    input  logic [STI_W_MAX-1:0] ld_word,
    input  logic [15:0]          ld_pi,
    input  logic [1:0]           ld_len,
    input  logic                 po_ready,
    output logic                 po_valid,
    output logic [STI_W_MAX-1:0] po_word,
    output logic [15:0]          po_pi,
    output logic [1:0]           po_len,
    output logic                 err_ovf
);

    logic can_load;
    assign can_load = !po_valid || po_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            po_valid <= 1'b0;
            po_word  <= '0;
            po_pi    <= '0;
            po_len   <= '0;
            err_ovf  <= 1'b0;
        end else begin
            if (ld && can_load) begin
                po_valid <= 1'b1;
                po_word  <= ld_word;
                po_pi    <= ld_pi;
                po_len   <= ld_len;
            end else if (po_valid && po_ready) begin
                po_valid <= 1'b0;
            end
            // A drop in the same cycle as a config load must stay visible.
            if (ld && !can_load) begin
                err_ovf <= 1'b1;
            end else if (clr) begin
                err_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sti_rx.sv
// STI serial-to-parallel receiver: po_valid rises one cycle after the last bit.
// Output is a one-entry ready/valid register; the serial side cannot be stalled.
module sti_rx
    import sti_rx_pkg::*;
#(
    parameter int W_MAX = STI_W_MAX,
    parameter int CNT_W = STI_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_load,
    input  logic [1:0] cfg_length,
    input  logic       cfg_msb,
    input  logic       cfg_fill,
    input  logic       cfg_low,
    sti_rx_if.slave    bus,
    output logic       err_short,
    output logic       err_long,
    output logic       err_pad,
    output logic       err_ovf
);

    rx_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, idx, k, nm1;
    logic [W_MAX-1:0] word, word_nxt;
    logic [1:0]       cfg_len_q, f_len, len_use;
    logic             cfg_msb_q, cfg_fill_q, cfg_low_q;
    logic             f_msb, f_fill, f_low, msb_use;
    logic             start, sample, complete, set_short, set_long, last_bit, done;
    pi_res_t          res;

    assign last_bit = (cnt == CNT_W'(nbits(f_len) - 6'd1));

    always_ff @(posedge clk) begin
        if (!reset) state <= RX_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RX_IDLE:    if (bus.si_valid) state_nxt = RX_RECV;
            RX_RECV:    if (!bus.si_valid) state_nxt = RX_IDLE;
                        else if (last_bit) state_nxt = RX_WAITLOW;
            RX_WAITLOW: if (!bus.si_valid) state_nxt = RX_IDLE;
            default:    state_nxt = RX_IDLE;
        endcase
    end

    always_comb begin
        start     = 1'b0;
        sample    = 1'b0;
        complete  = 1'b0;
        set_short = 1'b0;
        set_long  = 1'b0;
        case (state)
            RX_IDLE:    start = bus.si_valid;
            RX_RECV: begin
                sample    = bus.si_valid;
                complete  = bus.si_valid && last_bit;
                set_short = !bus.si_valid;
            end
            RX_WAITLOW: set_long = bus.si_valid;
            default: ;
        endcase
    end

    // The first bit is placed using the live config registers, later bits
    // use the per-frame snapshot.
    always_comb begin
        len_use  = start ? cfg_len_q : f_len;
        msb_use  = start ? cfg_msb_q : f_msb;
        k        = start ? '0 : cnt;
        nm1      = CNT_W'(nbits(len_use) - 6'd1);
        idx      = msb_use ? (nm1 - k) : k;
        word_nxt = start ? '0 : word;
        word_nxt[idx] = bus.si_data;
    end

    assign res = extract_pi(word, f_len, f_fill, f_low);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt        <= '0;
            word       <= '0;
            cfg_len_q  <= '0;
            cfg_msb_q  <= 1'b0;
            cfg_fill_q <= 1'b0;
            cfg_low_q  <= 1'b0;
            f_len      <= '0;
            f_msb      <= 1'b0;
            f_fill     <= 1'b0;
            f_low      <= 1'b0;
            done       <= 1'b0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
            err_pad    <= 1'b0;
        end else begin
            if (cfg_load) begin
                cfg_len_q  <= cfg_length;
                cfg_msb_q  <= cfg_msb;
                cfg_fill_q <= cfg_fill;
                cfg_low_q  <= cfg_low;
            end
            if (start) begin
                f_len  <= cfg_len_q;
                f_msb  <= cfg_msb_q;
                f_fill <= cfg_fill_q;
                f_low  <= cfg_low_q;
                word   <= word_nxt;
                cnt    <= CNT_W'(1);
            end else if (sample) begin
                word <= word_nxt;
                cnt  <= complete ? '0 : cnt + CNT_W'(1);
            end else if (set_short) begin
                word <= '0;
                cnt  <= '0;
            end
            done      <= complete;
            err_short <= set_short | (err_short & ~cfg_load);
            err_long  <= set_long  | (err_long  & ~cfg_load);
            err_pad   <= (done & res.pad_err) | (err_pad & ~cfg_load);
        end
    end

    sti_rx_obuf u_obuf (
        .clk      (clk),
        .reset    (reset),
        .clr      (cfg_load),
        .ld       (done),
        .ld_word  (word),
        .ld_pi    (res.pi),
        .ld_len   (f_len),
        .po_ready (bus.po_ready),
        .po_valid (bus.po_valid),
        .po_word  (bus.po_word),
        .po_pi    (bus.po_pi),
        .po_len   (bus.po_len),
        .err_ovf  (err_ovf)
    );

endmodule

// File: tb/tb_sti_rx.sv
// Directed bench for sti_rx: frames driven bit by bit, outputs checked against
// hand-computed words, payloads and error flags.
module tb_sti_rx;
    logic       clk;
    logic       reset;
    logic       cfg_load;
    logic [1:0] cfg_length;
    logic       cfg_msb, cfg_fill, cfg_low;
    logic       err_short, err_long, err_pad, err_ovf;
    int         checks;
    int         failures;

    sti_rx_if bus();

    sti_rx dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_load   (cfg_load),
        .cfg_length (cfg_length),
        .cfg_msb    (cfg_msb),
        .cfg_fill   (cfg_fill),
        .cfg_low    (cfg_low),
        .bus        (bus),
        .err_short  (err_short),
        .err_long   (err_long),
        .err_pad    (err_pad),
        .err_ovf    (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic set_cfg(input logic [1:0] len, input logic msb, input logic fill, input logic low);
        @(posedge clk); #1;
        cfg_load = 1'b1; cfg_length = len; cfg_msb = msb; cfg_fill = fill; cfg_low = low;
        @(posedge clk); #1;
        cfg_load = 1'b0;
    endtask

    // Drives n bits of val in link order, then optional extra high cycles, then low.
    task automatic send_frame(input logic [31:0] val, input int n, input logic msb, input int extra);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.si_valid = 1'b1;
            bus.si_data  = msb ? val[n-1-i] : val[i];
        end
        for (int i = 0; i < extra; i++) begin
            @(posedge clk); #1;
            bus.si_data = 1'b1;
        end
        @(posedge clk); #1;
        bus.si_valid = 1'b0;
        bus.si_data  = 1'b0;
    endtask

    task automatic accept();
        bus.po_ready = 1'b1;
        @(posedge clk); #1;
        bus.po_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.po_valid, bus.po_word, bus.po_pi, bus.po_len} !== 51'h0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b w=%h pi=%h len=%b exp all zero",
                     bus.po_valid, bus.po_word, bus.po_pi, bus.po_len);
        end
        checks++;
        if ({err_short, err_long, err_pad, err_ovf} !== 4'h0) begin
            failures++;
            $display("FAIL reset_errs got %b exp 0000", {err_short, err_long, err_pad, err_ovf});
        end
        reset = 1'b1;
    endtask

    task automatic test_len16();
        set_cfg(2'b01, 1'b1, 1'b0, 1'b0);
        send_frame(32'h0000A5C3, 16, 1'b1, 0);
        checks++;
        if (bus.po_valid !== 1'b0) begin
            failures++;
            $display("FAIL len16_early_valid got %b exp 0", bus.po_valid);
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.po_valid, bus.po_word, bus.po_pi, bus.po_len} !== {1'b1, 32'h0000A5C3, 16'hA5C3, 2'b01}) begin
            failures++;
            $display("FAIL len16_out got v=%b w=%h pi=%h len=%b exp v=1 w=0000a5c3 pi=a5c3 len=01",
                     bus.po_valid, bus.po_word, bus.po_pi, bus.po_len);
        end
        checks++;
        if ({err_short, err_long, err_pad, err_ovf} !== 4'h0) begin
            failures++;
            $display("FAIL len16_errs got %b exp 0000", {err_short, err_long, err_pad, err_ovf});
        end
        accept();
        checks++;
        if (bus.po_valid !== 1'b0) begin
            failures++;
            $display("FAIL len16_drop_after_accept got %b exp 0", bus.po_valid);
        end
    endtask

    task automatic test_len8();
        set_cfg(2'b00, 1'b0, 1'b0, 1'b1);
        send_frame(32'h0000003C, 8, 1'b0, 0);
        @(posedge clk); #1;
        checks++;
        if ({bus.po_valid, bus.po_word, bus.po_pi, bus.po_len} !== {1'b1, 32'h0000003C, 16'h3C00, 2'b00}) begin
            failures++;
            $display("FAIL len8_low1 got v=%b w=%h pi=%h len=%b exp v=1 w=0000003c pi=3c00 len=00",
                     bus.po_valid, bus.po_word, bus.po_pi, bus.po_len);
        end
        accept();
        set_cfg(2'b00, 1'b0, 1'b0, 1'b0);
        send_frame(32'h0000003C, 8, 1'b0, 0);
        @(posedge clk); #1;
        checks++;
        if ({bus.po_valid, bus.po_word, bus.po_pi} !== {1'b1, 32'h0000003C, 16'h003C}) begin
            failures++;
            $display("FAIL len8_low0 got v=%b w=%h pi=%h exp v=1 w=0000003c pi=003c",
                     bus.po_valid, bus.po_word, bus.po_pi);
        end
        accept();
    endtask

    task automatic test_pad();
        set_cfg(2'b10, 1'b1, 1'b1, 1'b0);
        send_frame(32'h00123400, 24, 1'b1, 0);
        @(posedge clk); #1;
        checks++;
        if ({bus.po_valid, bus.po_word, bus.po_pi, err_pad} !== {1'b1, 32'h00123400, 16'h1234, 1'b0}) begin
            failures++;
            $display("FAIL pad_clean got v=%b w=%h pi=%h pad=%b exp v=1 w=00123400 pi=1234 pad=0",
                     bus.po_valid, bus.po_word, bus.po_pi, err_pad);
        end
        accept();
        send_frame(32'h00123401, 24, 1'b1, 0);
        @(posedge clk); #1;
        checks++;
        if ({bus.po_valid, bus.po_word, bus.po_pi, err_pad} !== {1'b1, 32'h00123401, 16'h1234, 1'b1}) begin
            failures++;
            $display("FAIL pad_dirty got v=%b w=%h pi=%h pad=%b exp v=1 w=00123401 pi=1234 pad=1",
                     bus.po_valid, bus.po_word, bus.po_pi, err_pad);
        end
        accept();
    endtask

    task automatic test_ovf();
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        checks++;
        if (err_pad !== 1'b0) begin
            failures++;
            $display("FAIL cfg_clears_pad got %b exp 0", err_pad);
        end
        send_frame(32'h0000BEEF, 32, 1'b0, 0);
        @(posedge clk); #1;
        checks++;
        if ({bus.po_valid, bus.po_word, bus.po_pi, bus.po_len} !== {1'b1, 32'h0000BEEF, 16'hBEEF, 2'b11}) begin
            failures++;
            $display("FAIL len32_out got v=%b w=%h pi=%h len=%b exp v=1 w=0000beef pi=beef len=11",
                     bus.po_valid, bus.po_word, bus.po_pi, bus.po_len);
        end
        send_frame(32'h00001234, 32, 1'b0, 0);
        @(posedge clk); #1;
        checks++;
        if ({err_ovf, bus.po_valid, bus.po_word, bus.po_pi} !== {1'b1, 1'b1, 32'h0000BEEF, 16'hBEEF}) begin
            failures++;
            $display("FAIL ovf_drop got ovf=%b v=%b w=%h pi=%h exp ovf=1 v=1 w=0000beef pi=beef",
                     err_ovf, bus.po_valid, bus.po_word, bus.po_pi);
        end
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        send_frame(32'h0000CAFE, 32, 1'b0, 0);
        bus.po_ready = 1'b1;
        @(posedge clk); #1;
        bus.po_ready = 1'b0;
        checks++;
        if ({err_ovf, bus.po_valid, bus.po_word, bus.po_pi} !== {1'b0, 1'b1, 32'h0000CAFE, 16'hCAFE}) begin
            failures++;
            $display("FAIL ovf_swap got ovf=%b v=%b w=%h pi=%h exp ovf=0 v=1 w=0000cafe pi=cafe",
                     err_ovf, bus.po_valid, bus.po_word, bus.po_pi);
        end
        accept();
    endtask

    task automatic test_short_long();
        set_cfg(2'b00, 1'b0, 1'b0, 1'b0);
        send_frame(32'h0000001F, 5, 1'b0, 0);
        @(posedge clk); #1;
        checks++;
        if ({err_short, bus.po_valid} !== 2'b10) begin
            failures++;
            $display("FAIL short_frame got short=%b v=%b exp short=1 v=0", err_short, bus.po_valid);
        end
        send_frame(32'h00000081, 8, 1'b0, 0);
        @(posedge clk); #1;
        checks++;
        if ({bus.po_valid, bus.po_word, bus.po_pi, err_short} !== {1'b1, 32'h00000081, 16'h0081, 1'b1}) begin
            failures++;
            $display("FAIL after_short got v=%b w=%h pi=%h short=%b exp v=1 w=00000081 pi=0081 short=1",
                     bus.po_valid, bus.po_word, bus.po_pi, err_short);
        end
        accept();
        send_frame(32'h0000005A, 8, 1'b0, 3);
        checks++;
        if ({err_long, bus.po_valid, bus.po_word} !== {1'b1, 1'b1, 32'h0000005A}) begin
            failures++;
            $display("FAIL long_frame got long=%b v=%b w=%h exp long=1 v=1 w=0000005a",
                     err_long, bus.po_valid, bus.po_word);
        end
        accept();
    endtask

    task automatic test_reset_midframe();
        set_cfg(2'b11, 1'b1, 1'b0, 1'b0);
        send_frame(32'hFFFF0000, 32, 1'b1, 0);
        @(posedge clk); #1;
        checks++;
        if ({bus.po_valid, bus.po_pi, err_pad} !== {1'b1, 16'h0000, 1'b1}) begin
            failures++;
            $display("FAIL fill0_pad got v=%b pi=%h pad=%b exp v=1 pi=0000 pad=1",
                     bus.po_valid, bus.po_pi, err_pad);
        end
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            bus.si_valid = 1'b1;
            bus.si_data  = 1'b1;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        bus.si_valid = 1'b0;
        bus.si_data  = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        checks++;
        if ({bus.po_valid, bus.po_word, bus.po_pi, bus.po_len, err_short, err_long, err_pad, err_ovf} !== 55'h0) begin
            failures++;
            $display("FAIL midframe_reset got v=%b w=%h pi=%h len=%b errs=%b exp all zero",
                     bus.po_valid, bus.po_word, bus.po_pi, bus.po_len,
                     {err_short, err_long, err_pad, err_ovf});
        end
        send_frame(32'h000000A5, 8, 1'b0, 0);
        @(posedge clk); #1;
        checks++;
        if ({bus.po_valid, bus.po_word, bus.po_pi, bus.po_len} !== {1'b1, 32'h000000A5, 16'h00A5, 2'b00}) begin
            failures++;
            $display("FAIL post_reset got v=%b w=%h pi=%h len=%b exp v=1 w=000000a5 pi=00a5 len=00",
                     bus.po_valid, bus.po_word, bus.po_pi, bus.po_len);
        end
        accept();
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b0;
        cfg_load     = 1'b0;
        cfg_length   = 2'b00;
        cfg_msb      = 1'b0;
        cfg_fill     = 1'b0;
        cfg_low      = 1'b0;
        bus.si_valid = 1'b0;
        bus.si_data  = 1'b0;
        bus.po_ready = 1'b0;
        test_reset();
        test_len16();
        test_len8();
        test_pad();
        test_ovf();
        test_short_long();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
